// File: rtl/apb_master.sv
// APB requester: turns single-beat host commands into SETUP/ACCESS APB transfers with one response each.
// Optional ACCESS-phase timeout is enabled by defining APB_MASTER_TIMEOUT_EN.
module apb_master #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int SEL_BITS       = 2,
    parameter int TIMEOUT_CYCLES = 16,
    localparam int NUM_SLAVES    = 2**SEL_BITS,
    localparam int PSTRB_WIDTH   = DATA_WIDTH/8
) (
    input  logic                   PCLK,
    input  logic                   PRESET,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_write,
    input  logic [ADDR_WIDTH-1:0]  cmd_addr,
    input  logic [DATA_WIDTH-1:0]  cmd_wdata,
    input  logic [PSTRB_WIDTH-1:0] cmd_strb,
    input  logic [2:0]             cmd_prot,
    output logic                   rsp_valid,
    output logic [DATA_WIDTH-1:0]  rsp_rdata,
    output logic                   rsp_err,
    output logic [ADDR_WIDTH-1:0]  PADDR,
    output logic [2:0]             PPROT,
    output logic [NUM_SLAVES-1:0]  PSEL,
    output logic                   PENABLE,
    output logic                   PWRITE,
    output logic [DATA_WIDTH-1:0]  PWDATA,
    output logic [PSTRB_WIDTH-1:0] PSTRB,
    input  logic [DATA_WIDTH-1:0]  PRDATA,
    input  logic                   PREADY,
    input  logic                   PSLVERR
);

    // state  | meaning
    // IDLE   | no transfer, host may issue a command
    // SETUP  | PSEL up, PENABLE low, exactly one cycle
    // ACCESS | PENABLE up, waiting for PREADY
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t                state;
    logic                  accept;
    logic                  tmo_hit;
    logic [NUM_SLAVES-1:0] sel_dec;

    if (SEL_BITS < 1 || SEL_BITS > ADDR_WIDTH || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("apb_master: invalid SEL_BITS/TIMEOUT_CYCLES");
    end

    always_comb begin
        sel_dec = '0;
        sel_dec[cmd_addr[ADDR_WIDTH-1 -: SEL_BITS]] = 1'b1;
    end

    // Ready during the completing ACCESS cycle gives back-to-back transfers without an IDLE bubble.
    assign cmd_ready = !PRESET && ((state == IDLE) || (state == ACCESS && PREADY));
    assign accept    = cmd_valid && cmd_ready;

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_cnt;

    // Abort on the TIMEOUT_CYCLES-th wait cycle; a PREADY in that same cycle still completes normally.
    assign tmo_hit = (state == ACCESS) && !PREADY && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            tmo_cnt <= '0;
        end else if (state == SETUP) begin
            tmo_cnt <= '0;
        end else if (state == ACCESS && !PREADY) begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state     <= IDLE;
            PADDR     <= '0;
            PPROT     <= '0;
            PSEL      <= '0;
            PENABLE   <= 1'b0;
            PWRITE    <= 1'b0;
            PWDATA    <= '0;
            PSTRB     <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                SETUP: begin
                    PENABLE <= 1'b1;
                    state   <= ACCESS;
                end
                ACCESS: begin
                    if (PREADY) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= PSLVERR;
                        rsp_rdata <= PWRITE ? '0 : PRDATA;
                        PSEL      <= '0;
                        PENABLE   <= 1'b0;
                        state     <= IDLE;
                    end else if (tmo_hit) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_rdata <= '0;
                        PSEL      <= '0;
                        PENABLE   <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: ;
            endcase
            // A new command overrides the return to IDLE taken above.
            if (accept) begin
                PADDR   <= cmd_addr;
                PPROT   <= cmd_prot;
                PWRITE  <= cmd_write;
                PWDATA  <= cmd_write ? cmd_wdata : '0;
                PSTRB   <= cmd_write ? cmd_strb : '0;
                PSEL    <= sel_dec;
                PENABLE <= 1'b0;
                state   <= SETUP;
            end
        end
    end

endmodule

// File: doc/apb_master.md
Name: apb_master

Overview:
APB requester that drives the slave side of our APB fabric. It takes single-beat read/write commands from a local host over a valid/ready command port. Each command becomes a standard SETUP→ACCESS APB transfer. PSEL is one-hot decoded from the top address bits, and every transfer returns exactly one response pulse carrying PRDATA/PSLVERR to the host.

Parameters:
ADDR_WIDTH, 32, width of cmd_addr/PADDR
DATA_WIDTH, 32, width of data buses
SEL_BITS, 2, number of top PADDR bits decoded into PSEL; NUM_SLAVES = 2**SEL_BITS (localparam)
TIMEOUT_CYCLES, 16, maximum ACCESS cycles with PREADY low before abort (used only with the optional feature)
PSTRB_WIDTH (localparam), DATA_WIDTH/8

Ports:
PCLK  in  1  clock
PRESET  in  1  asynchronous, active-high reset
cmd_valid  in  1  host command valid
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
cmd_write  in  1  1=write, 0=read
cmd_addr  in  ADDR_WIDTH  transfer address
cmd_wdata  in  DATA_WIDTH  write data
cmd_strb  in  PSTRB_WIDTH  write byte strobes
cmd_prot  in  3  protection attributes
rsp_valid  out  1  one-cycle response pulse
rsp_rdata  out  DATA_WIDTH  read data (0 for writes)
rsp_err  out  1  PSLVERR captured at completion (or timeout)
PADDR  out  ADDR_WIDTH  APB address
PPROT  out  3  APB protection
PSEL  out  NUM_SLAVES  one-hot slave select
PENABLE  out  1  APB enable
PWRITE  out  1  APB direction
PWDATA  out  DATA_WIDTH  APB write data
PSTRB  out  PSTRB_WIDTH  APB strobes
PRDATA  in  DATA_WIDTH  slave read data
PREADY  in  1  slave ready
PSLVERR  in  1  slave error

Behaviour:
- Reset (async, PRESET=1): state IDLE. All APB outputs 0, rsp_valid=0, rsp_rdata=0, rsp_err=0, cmd_ready=0 while PRESET is high. After release, cmd_ready=1 in IDLE.
- Reset mid-transfer aborts immediately. PSEL/PENABLE drop asynchronously. No response is issued.
- All APB and response outputs are registered.
- FSM states: IDLE, SETUP, ACCESS.
  - IDLE: cmd_ready=1. On accept, register the command into PADDR/PPROT/PWRITE/PWDATA/PSTRB, set PSEL[cmd_addr[ADDR_WIDTH-1 -: SEL_BITS]]=1, PENABLE=0, and go to SETUP.
  - SETUP: lasts exactly one cycle. PENABLE goes to 1 and the state moves to ACCESS.
  - ACCESS: hold all APB outputs stable while PREADY=0. On PREADY=1, the transfer completes at that edge:
    - capture PSLVERR into rsp_err;
    - capture rsp_rdata=PRDATA for reads, 0 for writes;
    - pulse rsp_valid on the next cycle.
- After completion, with cmd_valid=1: the command is accepted in the completion cycle (cmd_ready=PREADY in ACCESS) and the FSM goes straight to SETUP with PENABLE=0. No IDLE bubble.
- After completion, with cmd_valid=0: PSEL=0, PENABLE=0, FSM goes to IDLE.
- Reads drive PSTRB=0 and PWDATA=0. Writes drive cmd_strb unchanged.
- Latency:
  - from the accept edge, PSEL rises in the next cycle;
  - the minimum transfer is 2 APB cycles;
  - rsp_valid follows the completion edge.
- Exactly one PSEL bit is high during SETUP/ACCESS; all bits are 0 otherwise.
- cmd_* inputs are ignored when cmd_ready=0. PADDR is never changed mid-transfer.
- PSLVERR is sampled only in ACCESS with PREADY=1 and is ignored otherwise.

Optional Feature:
APB_MASTER_TIMEOUT_EN
- Defined:
  - A counter clears on entry to ACCESS and increments each ACCESS cycle with PREADY=0.
  - When the count reaches TIMEOUT_CYCLES, the transfer aborts:
    - PSEL and PENABLE are 0 in the next cycle;
    - rsp_valid is pulsed with rsp_err=1 and rsp_rdata=0;
    - FSM returns to IDLE (no back-to-back accept in the abort cycle).
  - PREADY=1 in the same cycle as the count reaching TIMEOUT_CYCLES counts as normal completion (PREADY wins).
- Not defined: the master waits in ACCESS indefinitely, the counter is absent, and TIMEOUT_CYCLES is unused.

Test Plan:
- Write cmd_addr=0x4000_0010, wdata=0xDEADBEEF, strb=0xF, PREADY tied 1 → PSEL=4'b0010 for 2 cycles, PENABLE only in cycle 2, PWDATA stable; rsp_valid=1 with rsp_err=0 and rsp_rdata=0.
- Read addr=0xC000_0004, slave holds PREADY=0 for 3 ACCESS cycles then returns PRDATA=0x1234_5678 → PSEL=4'b1000, PSTRB=0; rsp_rdata=0x1234_5678, rsp_err=0 one cycle after completion.
- Back-to-back write to 0x0000_0000 then read from 0x8000_0000, cmd_valid held → second SETUP immediately follows the first ACCESS; PSEL changes 0001→0100 with PENABLE=0 between them; two rsp_valid pulses.
- Slave returns PREADY=1 with PSLVERR=1 on a read → rsp_err=1, rsp_rdata=PRDATA as sampled.
- PRESET asserted during ACCESS → PSEL=0 and PENABLE=0 immediately, no rsp_valid; after release, a new write completes normally.
- With APB_MASTER_TIMEOUT_EN and PREADY stuck at 0 → abort after 16 wait cycles with rsp_err=1 and PSEL cleared.
